pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Fetch-PC sequencer with branch-prediction shadowing and misprediction
// recovery for a short in-order pipeline (IF -> ID -> EX).
//
// Every ID-stage branch that enters the pipe pushes a shadow entry that
// records what the front end assumed about it: the predicted direction, the
// fall-through address (id_pc + 4) and the predicted target. When the branch
// resolves in EX, the oldest shadow entry is popped and compared with the
// resolved outcome. If they disagree, the younger wrong-path work is flushed,
// the shadow queue is emptied and fetch restarts at the correct address.
//
// Control FSM:
//   BOOT    : one cycle after reset; pc_f holds RESET_PC, fetch_valid = 0.
//   RUN     : normal sequencing; predicted-taken ID branches redirect fetch.
//   RECOVER : one bubble cycle after a misprediction; pc_f already holds the
//             corrected address and is held so the first fetch at it is
//             tagged valid once back in RUN.
//
// Parameters:
//   RESET_PC : fetch address loaded on reset.
//   DEPTH    : shadow queue entries; power of two in 2..8.
//
// Ports:
//   clk            : clock, all state updates on the rising edge.
//   reset          : synchronous active-high reset.
//   stall          : hazard stall; holds pc_f and blocks shadow pushes.
//   id_valid       : ID stage holds a valid instruction.
//   id_is_branch   : ID instruction is a branch or jump.
//   id_pred_taken  : predicted direction of the ID instruction.
//   id_pc          : PC of the ID instruction.
//   id_target      : computed target of the ID instruction.
//   ex_valid       : EX stage holds a valid instruction.
//   ex_is_branch   : EX instruction is a branch resolving this cycle.
//   ex_taken       : resolved direction.
//   ex_target      : resolved target.
//   pc_f           : registered fetch PC.
//   fetch_valid    : the fetch at pc_f is on the correct path.
//   flush_if       : kill IF/ID contents at the next edge.
//   flush_id       : kill ID/EX contents at the next edge.
//   mispredict     : EX misprediction detected this cycle (combinational).
//   mispredict_cnt : saturating count of mispredictions.
//   shadow_err     : sticky shadow-queue overflow/underflow flag.
// ----------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        id_valid,
    input  logic        id_is_branch,
    input  logic        id_pred_taken,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic [31:0] pc_f,
    output logic        fetch_valid,
    output logic        flush_if,
    output logic        flush_id,
    output logic        mispredict,
    output logic [15:0] mispredict_cnt,
    output logic        shadow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StBoot    = 2'd0,
        StRun     = 2'd1,
        StRecover = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e             state_q;
    logic               fetch_valid_q;
    logic [31:0]        pc_q;
    logic [31:0]        pc_d;
    logic [15:0]        miss_cnt_q;
    logic               err_q;

    // Shadow queue storage: one field per array, indexed by the ring pointers.
    logic [DEPTH-1:0]   sh_taken_q;
    logic [31:0]        sh_fall_q   [DEPTH];
    logic [31:0]        sh_target_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic               active;
    logic               in_run;
    logic               sh_empty;
    logic               sh_full;
    logic               head_taken;
    logic [31:0]        head_fall;
    logic [31:0]        head_target;
    logic               pop_req;
    logic               pop_ok;
    logic               push_req;
    logic               push_ok;
    logic               id_redirect;
    logic               miss;
    logic               overflow;
    logic               underflow;

    assign active      = ~reset;
    assign in_run      = (state_q == StRun);
    assign sh_empty    = (count_q == '0);
    assign sh_full     = (count_q == CNT_W'(DEPTH));

    assign head_taken  = sh_taken_q[rd_ptr_q];
    assign head_fall   = sh_fall_q[rd_ptr_q];
    assign head_target = sh_target_q[rd_ptr_q];

    // EX resolution only counts in RUN; in BOOT and RECOVER the EX stage
    // holds flushed or not-yet-started work.
    assign pop_req = ex_valid & ex_is_branch & in_run;
    assign pop_ok  = pop_req & ~sh_empty;

    // A taken branch must also match the predicted target; a correctly
    // predicted not-taken branch does not care what target was computed.
    assign miss = active & pop_ok &
                  ((ex_taken != head_taken) | (ex_taken & (ex_target != head_target)));

    assign push_req    = id_valid & id_is_branch & ~stall & ~miss & in_run;
    // A full queue still accepts a push when the head leaves the same cycle.
    assign push_ok     = push_req & (~sh_full | pop_ok);
    assign id_redirect = active & push_req & id_pred_taken;

    assign overflow    = push_req & sh_full & ~pop_ok;
    assign underflow   = pop_req & sh_empty;

    // ------------------------------------------------------------------------
    // Next fetch PC
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d = pc_q;
        if (miss) begin
            pc_d = ex_taken ? ex_target : head_fall;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (!in_run) begin
            // BOOT holds RESET_PC; RECOVER holds the corrected address.
            pc_d = pc_q;
        end else if (id_redirect) begin
            pc_d = id_target;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered fetch_valid
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StBoot;
            fetch_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StBoot: begin
                    state_q       <= StRun;
                    fetch_valid_q <= 1'b1;
                end
                StRun: begin
                    if (miss) begin
                        state_q       <= StRecover;
                        fetch_valid_q <= 1'b0;
                    end
                end
                StRecover: begin
                    state_q       <= StRun;
                    fetch_valid_q <= 1'b1;
                end
                default: begin
                    state_q       <= StBoot;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Shadow queue pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (miss) begin
            // Everything younger than the mispredicted branch is wrong-path.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (active && !miss && push_ok) begin
            sh_taken_q[wr_ptr_q]  <= id_pred_taken;
            sh_fall_q[wr_ptr_q]   <= id_pc + 32'd4;
            sh_target_q[wr_ptr_q] <= id_target;
        end
    end

    // ------------------------------------------------------------------------
    // Status counters and flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (miss && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            if (overflow || underflow) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pc_f           = pc_q;
    assign fetch_valid    = fetch_valid_q;
    assign mispredict     = miss;
    assign flush_if       = miss | id_redirect;
    assign flush_id       = miss;
    assign mispredict_cnt = miss_cnt_q;
    assign shadow_err     = err_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Directed bench for pc_redirect_ctrl (RESET_PC = 0, DEPTH = 2). A queue-based
// reference model predicts every output each cycle; literal expectations at
// each step of the directed script pin the model to hand-worked values.
// ----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        id_valid;
    logic        id_is_branch;
    logic        id_pred_taken;
    logic [31:0] id_pc;
    logic [31:0] id_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] pc_f;
    logic        fetch_valid;
    logic        flush_if;
    logic        flush_id;
    logic        mispredict;
    logic [15:0] mispredict_cnt;
    logic        shadow_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_is_branch   (id_is_branch),
        .id_pred_taken  (id_pred_taken),
        .id_pc          (id_pc),
        .id_target      (id_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .pc_f           (pc_f),
        .fetch_valid    (fetch_valid),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .mispredict     (mispredict),
        .mispredict_cnt (mispredict_cnt),
        .shadow_err     (shadow_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: shadow queue as an SV queue, PC as plain arithmetic.
    // Evaluated on the falling edge, where inputs are stable.
    // ------------------------------------------------------------------------
    typedef struct {
        bit          taken;
        logic [31:0] fall;
        logic [31:0] target;
    } pred_t;

    typedef enum {MBoot, MRun, MRecover} mode_t;

    pred_t       shq[$];
    mode_t       m_mode;
    logic [31:0] m_pc;
    int          m_miss;
    bit          m_err;
    bit          m_init = 0;

    always @(negedge clk) begin
        bit    run, pop, mp, push, redir;
        pred_t e;
        if (m_init) begin
            run   = (m_mode == MRun);
            pop   = !reset && ex_valid && ex_is_branch && run;
            mp    = pop && shq.size() > 0 &&
                    (ex_taken != shq[0].taken || (ex_taken && ex_target != shq[0].target));
            push  = !reset && id_valid && id_is_branch && !stall && !mp && run;
            redir = push && id_pred_taken;

            chk("model_pc_f", pc_f, m_pc);
            chk("model_fetch_valid", fetch_valid, run);
            chk("model_mispredict", mispredict, mp);
            chk("model_flush_if", flush_if, mp || redir);
            chk("model_flush_id", flush_id, mp);
            chk("model_mispredict_cnt", mispredict_cnt, m_miss);
            chk("model_shadow_err", shadow_err, m_err);

            if (reset) begin
                m_pc   = RST_PC;
                m_mode = MBoot;
                shq.delete();
                m_miss = 0;
                m_err  = 0;
            end else if (mp) begin
                m_pc = ex_taken ? ex_target : shq[0].fall;
                shq.delete();
                if (m_miss < 65535) m_miss++;
                m_mode = MRecover;
            end else begin
                if (pop) begin
                    if (shq.size() == 0) m_err = 1;
                    else shq.delete(0);
                end
                if (push) begin
                    if (shq.size() >= DEPTH) begin
                        m_err = 1;
                    end else begin
                        e.taken  = id_pred_taken;
                        e.fall   = id_pc + 32'd4;
                        e.target = id_target;
                        shq.push_back(e);
                    end
                end
                if (run && !stall) m_pc = redir ? id_target : m_pc + 32'd4;
                m_mode = MRun;
            end
        end else if (reset) begin
            m_init = 1;
            m_pc   = RST_PC;
            m_mode = MBoot;
            shq.delete();
            m_miss = 0;
            m_err  = 0;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic clear_inputs();
        stall         = 1'b0;
        id_valid      = 1'b0;
        id_is_branch  = 1'b0;
        id_pred_taken = 1'b0;
        id_pc         = '0;
        id_target     = '0;
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_taken      = 1'b0;
        ex_target     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic id_br(input logic pt, input logic [31:0] pc, input logic [31:0] tgt);
        id_valid      = 1'b1;
        id_is_branch  = 1'b1;
        id_pred_taken = pt;
        id_pc         = pc;
        id_target     = tgt;
    endtask

    task automatic ex_br(input logic tk, input logic [31:0] tgt);
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_taken     = tk;
        ex_target    = tgt;
    endtask

    // ------------------------------------------------------------------------
    // Directed script
    // ------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        // BOOT
        chk("boot_pc", pc_f, 32'h0);
        chk("boot_fetch_valid", fetch_valid, 0);
        chk("boot_cnt", mispredict_cnt, 0);
        chk("boot_err", shadow_err, 0);
        tick(); #1;
        chk("run0_pc", pc_f, 32'h0);
        chk("run0_fetch_valid", fetch_valid, 1);
        tick(); #1;
        chk("run1_pc", pc_f, 32'h4);
        tick(); #1;
        chk("run2_pc", pc_f, 32'h8);

        // Predicted-taken branch, resolved correctly
        tick(); id_br(1'b1, 32'h10, 32'h40); #1;
        chk("idred_pc", pc_f, 32'hC);
        chk("idred_flush_if", flush_if, 1);
        chk("idred_flush_id", flush_id, 0);
        tick(); ex_br(1'b1, 32'h40); #1;
        chk("idred_target_pc", pc_f, 32'h40);
        chk("idred_resolve_mp", mispredict, 0);
        chk("idred_resolve_flush_if", flush_if, 0);

        // Predicted not-taken, actually taken to 0x80
        tick(); id_br(1'b0, 32'h20, 32'h60); #1;
        chk("nt_push_pc", pc_f, 32'h44);
        chk("nt_push_flush_if", flush_if, 0);
        tick(); ex_br(1'b1, 32'h80); #1;
        chk("nt_miss_pc", pc_f, 32'h48);
        chk("nt_miss_mp", mispredict, 1);
        chk("nt_miss_flush_if", flush_if, 1);
        chk("nt_miss_flush_id", flush_id, 1);
        tick(); #1;
        chk("nt_recover_pc", pc_f, 32'h80);
        chk("nt_recover_fv", fetch_valid, 0);
        chk("nt_recover_cnt", mispredict_cnt, 1);
        tick(); #1;
        chk("nt_back_pc", pc_f, 32'h80);
        chk("nt_back_fv", fetch_valid, 1);

        // Predicted taken to 0x100, actually not-taken -> fall-through 0x34
        tick(); id_br(1'b1, 32'h30, 32'h100); #1;
        chk("tk_push_pc", pc_f, 32'h84);
        chk("tk_push_flush_if", flush_if, 1);
        tick(); ex_br(1'b0, 32'h100); #1;
        chk("tk_miss_pc", pc_f, 32'h100);
        chk("tk_miss_mp", mispredict, 1);
        tick(); #1;
        chk("tk_recover_pc", pc_f, 32'h34);
        chk("tk_recover_fv", fetch_valid, 0);
        chk("tk_recover_cnt", mispredict_cnt, 2);

        // Overflow: three pushes into a 2-entry queue (also proves the clear)
        tick(); id_br(1'b0, 32'h200, 32'h300); #1;
        chk("ovf_a_pc", pc_f, 32'h34);
        chk("ovf_a_fv", fetch_valid, 1);
        tick(); id_br(1'b0, 32'h204, 32'h304); #1;
        chk("ovf_b_pc", pc_f, 32'h38);
        chk("ovf_b_err", shadow_err, 0);
        tick(); id_br(1'b0, 32'h208, 32'h308); #1;
        chk("ovf_c_pc", pc_f, 32'h3C);
        chk("ovf_c_err", shadow_err, 0);
        tick(); ex_br(1'b0, 32'h0); #1;
        chk("ovf_err_set", shadow_err, 1);
        chk("ovf_pop_a_mp", mispredict, 0);
        tick(); ex_br(1'b0, 32'h0); #1;
        chk("ovf_pop_b_pc", pc_f, 32'h44);
        chk("ovf_pop_b_mp", mispredict, 0);
        // Dropped third entry must not exist: this pop hits an empty queue
        tick(); ex_br(1'b1, 32'h500); #1;
        chk("ovf_dropped_mp", mispredict, 0);
        tick(); id_br(1'b0, 32'h400, 32'h410); #1;
        chk("ovf_err_sticky", shadow_err, 1);
        chk("ovf_push_pc", pc_f, 32'h4C);

        // Reset while a mispredict and an ID redirect are both pending
        tick(); reset = 1'b1; ex_br(1'b1, 32'h999); id_br(1'b1, 32'h500, 32'h600); #1;
        chk("rst_mp", mispredict, 0);
        chk("rst_flush_if", flush_if, 0);
        chk("rst_flush_id", flush_id, 0);
        tick(); reset = 1'b0; #1;
        chk("rst_pc", pc_f, RST_PC);
        chk("rst_fv", fetch_valid, 0);
        chk("rst_err", shadow_err, 0);
        chk("rst_cnt", mispredict_cnt, 0);
        tick(); #1;
        chk("rst_run_pc", pc_f, 32'h0);

        // Underflow: pop on empty queue
        tick(); ex_br(1'b1, 32'h20); #1;
        chk("unf_pc", pc_f, 32'h4);
        chk("unf_mp", mispredict, 0);
        tick(); id_br(1'b0, 32'h700, 32'h710); #1;
        chk("unf_err", shadow_err, 1);
        chk("unf_push_pc", pc_f, 32'h8);

        // Stall together with an EX mispredict: redirect wins
        tick(); stall = 1'b1; ex_br(1'b1, 32'h900); id_br(1'b1, 32'h800, 32'hA00); #1;
        chk("stmp_pc", pc_f, 32'hC);
        chk("stmp_mp", mispredict, 1);
        chk("stmp_flush_if", flush_if, 1);
        chk("stmp_flush_id", flush_id, 1);
        tick(); #1;
        chk("stmp_redirect_pc", pc_f, 32'h900);
        chk("stmp_cnt", mispredict_cnt, 1);

        // Stall alone: hold PC, suppress push and ID redirect
        tick(); stall = 1'b1; id_br(1'b1, 32'h800, 32'hA00); #1;
        chk("st1_pc", pc_f, 32'h900);
        chk("st1_flush_if", flush_if, 0);
        tick(); stall = 1'b1; id_br(1'b1, 32'h800, 32'hA00); #1;
        chk("st2_pc", pc_f, 32'h900);
        chk("st2_flush_if", flush_if, 0);
        // A suppressed push leaves the queue empty, so no mispredict here
        tick(); ex_br(1'b0, 32'h0); #1;
        chk("st_release_pc", pc_f, 32'h900);
        chk("st_nopush_mp", mispredict, 0);
        tick(); #1;
        chk("st_inc_pc", pc_f, 32'h904);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
